result_unloader: RTL

RESULT_UNLOADER -- requirements
Module: result_unloader

---
 rtl/result_unloader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/result_unloader.sv
// result_unloader
//   Captures the skewed outputs of a 4-column systolic array into a 4x4
//   row-major buffer, then streams the 16 elements out over a valid/ready port.
//
//   Ports:
//     clk, rst              clock; synchronous active-high reset
//     start                 begin one capture/drain pass (honoured only in IDLE)
//     col_in0..col_in3      skewed column outputs of the array
//     out_data, out_valid   result element stream
//     out_ready             consumer accepts out_data
//     busy                  high whenever the FSM is not in IDLE
//     done                  one-cycle pulse after the 16th element is accepted
//     state_dbg             current FSM state (IDLE=0, WAIT=1, CAPTURE=2, DRAIN=3)
//
//   Handshake: an element transfers on every rising edge where out_valid and
//   out_ready are both 1. out_valid is only ever high in DRAIN, and while it is
//   high and out_ready is low, out_data and the read index hold unchanged.
//
//   Timing, with E0 the edge that samples start in IDLE: WAIT runs until edge
//   E0+FIRST_LAT-1, columns are sampled on edges E0+FIRST_LAT+s (s=0..6), and
//   the first element is presented after edge E0+FIRST_LAT+6.
module result_unloader #(
  parameter int DATA_W    = 8,
  parameter int FIRST_LAT = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] col_in0,
  input  logic [DATA_W-1:0] col_in1,
  input  logic [DATA_W-1:0] col_in2,
  input  logic [DATA_W-1:0] col_in3,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  // WAIT leaves on edge E0+FIRST_LAT-1; the counter is 0 after E0, so the
  // exit value is FIRST_LAT-2. With FIRST_LAT=1 WAIT is skipped entirely.
  localparam logic [7:0] WAIT_LAST = 8'(FIRST_LAT - 2);

  state_t            state_q, state_d;
  logic [7:0]        wait_cnt;
  logic [2:0]        step;
  logic [3:0]        rd_idx;
  logic              done_q;
  logic [DATA_W-1:0] buf_q [16];
  logic [DATA_W-1:0] col   [4];

  assign col[0] = col_in0;
  assign col[1] = col_in1;
  assign col[2] = col_in2;
  assign col[3] = col_in3;

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done_q) begin
          state_d = (FIRST_LAT == 1) ? ST_CAPTURE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (wait_cnt == WAIT_LAST) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        busy = 1'b1;
        if (step == 3'd6) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = buf_q[rd_idx];
        if (out_ready && rd_idx == 4'd15) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wait_cnt <= '0;
      step     <= '0;
      rd_idx   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_DRAIN) && out_ready && (rd_idx == 4'd15);

      if (state_q == ST_WAIT) wait_cnt <= wait_cnt + 8'd1;
      else                    wait_cnt <= '0;

      if (state_q == ST_CAPTURE) step <= step + 3'd1;
      else                       step <= '0;

      // The last transfer returns the index to 0 rather than wrapping a read.
      if (state_q == ST_DRAIN) begin
        if (out_ready) rd_idx <= (rd_idx == 4'd15) ? 4'd0 : rd_idx + 4'd1;
      end else begin
        rd_idx <= '0;
      end
    end
  end

  // Column c carries row (s-c) at capture step s; outside that diagonal
  // window its value belongs to another tile and is ignored. The buffer is
  // not reset and keeps its contents between passes.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_CAPTURE) begin
      for (int c = 0; c < 4; c++) begin
        automatic int r = int'(step) - c;
        if (r >= 0 && r <= 3) begin
          buf_q[4'(r * 4 + c)] <= col[c];
        end
      end
    end
  end

  assign done      = done_q;
  assign state_dbg = state_q;

endmodule
